funcao_lut_varredura: RTL and testbench

Parametrised, programmable N-input Boolean function unit. It is the sequential successor to the fixed two-to-four-input combinational functions of Guia 04. The function is held as a loadable truth table. The block evaluates single input vectors through a valid/ready handshake, and it can also sweep all 2^N input combinations automatically, streaming (input, output) pairs so the bench or a downstream checker can rebuild the full truth table and the Karnaugh map.

---
 rtl/funcao_pkg.sv | 17 +
 rtl/contador_varredura.sv | 33 +++
 rtl/funcao_lut_varredura.sv | 169 ++++++++++++++++
 tb/tb_funcao_lut_varredura.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/funcao_pkg.sv
// Shared definitions for the programmable LUT function unit with truth-table sweep.
package funcao_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned N_MIN = 1;
    localparam int unsigned N_MAX = 6;

    function automatic bit n_legal(input int unsigned n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/contador_varredura.sv
// Up-counter with synchronous clear and enable; clear and enable together yield 1.
module contador_varredura #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o,
    output logic         last_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = clr_i ? '0 : q_q;
        if (en_i) begin
            q_d = q_d + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign last_o = (q_q == {W{1'b1}});

endmodule

// File: rtl/funcao_lut_varredura.sv
// Programmable N-input Boolean function: single evaluations or a full truth-table sweep.
// Optional minterm counter enabled by defining FUNCAO_MINTERM_COUNT_EN.
module funcao_lut_varredura
    import funcao_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned TT_W = 1 << N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [TT_W-1:0] cfg_tt,
    input  logic            in_valid,
    input  logic [N-1:0]    in_x,
    output logic            in_ready,
    input  logic            sweep_start,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_x,
    output logic            out_f,
    output logic            sweep_busy,
    output logic            sweep_done
`ifdef FUNCAO_MINTERM_COUNT_EN
    ,
    output logic [N:0]      minterm_count
`endif
);

    if (!n_legal(N)) begin : g_bad_n
        $error("funcao_lut_varredura: N must be in 1..6");
    end

    state_e          state_q, state_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_x_q, out_x_d;
    logic            out_f_q, out_f_d;
    logic            sweep_done_q, sweep_done_d;

    logic            slot_free;
    logic            load_en;
    logic [N-1:0]    load_x;
    logic            load_f;
    logic            idx_clr, idx_en, idx_last;
    logic [N-1:0]    idx;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_IDLE) && !sweep_start && slot_free;

    contador_varredura #(
        .W (N)
    ) u_idx (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (idx_clr),
        .en_i   (idx_en),
        .q_o    (idx),
        .last_o (idx_last)
    );

    always_comb begin
        state_d      = state_q;
        tt_d         = tt_q;
        sweep_done_d = 1'b0;
        idx_clr      = 1'b0;
        idx_en       = 1'b0;
        load_en      = 1'b0;
        load_x       = '0;
        load_f       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    tt_d = cfg_tt;
                end
                if (sweep_start) begin
                    state_d = ST_SWEEP;
                    idx_clr = 1'b1;
                    // Entry 0 goes out on the start edge so results begin one cycle later.
                    if (slot_free) begin
                        load_en = 1'b1;
                        load_f  = tt_q[0];
                        idx_en  = 1'b1;
                    end
                end else if (in_valid && slot_free) begin
                    load_en = 1'b1;
                    load_x  = in_x;
                    load_f  = tt_q[in_x];
                end
            end
            ST_SWEEP: begin
                if (slot_free) begin
                    load_en = 1'b1;
                    load_x  = idx;
                    load_f  = tt_q[idx];
                    idx_en  = !idx_last;
                    if (idx_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (slot_free) begin
                    state_d      = ST_IDLE;
                    sweep_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = load_en || (out_valid_q && !out_ready);
        out_x_d     = load_en ? load_x : out_x_q;
        out_f_d     = load_en ? load_f : out_f_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tt_q         <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_f_q      <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tt_q         <= tt_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_f_q      <= out_f_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_f      = out_f_q;
    assign sweep_busy = (state_q != ST_IDLE);
    assign sweep_done = sweep_done_q;

`ifdef FUNCAO_MINTERM_COUNT_EN
    logic load_sweep, out_sweep_q, out_sweep_d, mc_en, mc_last_unused;

    // Marks slot contents produced by a sweep, so single evaluations never count.
    assign load_sweep  = (state_q != ST_IDLE) || sweep_start;
    assign out_sweep_d = load_en ? load_sweep : out_sweep_q;
    assign mc_en       = out_valid_q && out_ready && out_sweep_q && out_f_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sweep_q <= 1'b0;
        end else begin
            out_sweep_q <= out_sweep_d;
        end
    end

    contador_varredura #(
        .W (N + 1)
    ) u_minterm (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (idx_clr),
        .en_i   (mc_en),
        .q_o    (minterm_count),
        .last_o (mc_last_unused)
    );
`endif

endmodule

// File: tb/tb_funcao_lut_varredura.sv
// Self-checking bench for funcao_lut_varredura (N=3 main instance, N=2 side instance).
module tb_funcao_lut_varredura;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=3 instance
    logic       a_cfg_we = 1'b0, a_in_valid = 1'b0, a_sweep_start = 1'b0, a_out_ready = 1'b1;
    logic [7:0] a_cfg_tt = '0;
    logic [2:0] a_in_x = '0;
    logic       a_in_ready, a_out_valid, a_out_f, a_sweep_busy, a_sweep_done;
    logic [2:0] a_out_x;
    logic [3:0] a_mc;

    // N=2 instance
    logic       b_cfg_we = 1'b0, b_in_valid = 1'b0, b_sweep_start = 1'b0, b_out_ready = 1'b1;
    logic [3:0] b_cfg_tt = '0;
    logic [1:0] b_in_x = '0;
    logic       b_in_ready, b_out_valid, b_out_f, b_sweep_busy, b_sweep_done;
    logic [1:0] b_out_x;
    logic [2:0] b_mc;

    funcao_lut_varredura #(.N(3)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (a_cfg_we),
        .cfg_tt      (a_cfg_tt),
        .in_valid    (a_in_valid),
        .in_x        (a_in_x),
        .in_ready    (a_in_ready),
        .sweep_start (a_sweep_start),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_x       (a_out_x),
        .out_f       (a_out_f),
        .sweep_busy  (a_sweep_busy),
        .sweep_done  (a_sweep_done)
`ifdef FUNCAO_MINTERM_COUNT_EN
        ,
        .minterm_count (a_mc)
`endif
    );

    funcao_lut_varredura #(.N(2)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (b_cfg_we),
        .cfg_tt      (b_cfg_tt),
        .in_valid    (b_in_valid),
        .in_x        (b_in_x),
        .in_ready    (b_in_ready),
        .sweep_start (b_sweep_start),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_x       (b_out_x),
        .out_f       (b_out_f),
        .sweep_busy  (b_sweep_busy),
        .sweep_done  (b_sweep_done)
`ifdef FUNCAO_MINTERM_COUNT_EN
        ,
        .minterm_count (b_mc)
`endif
    );

`ifndef FUNCAO_MINTERM_COUNT_EN
    assign a_mc = '0;
    assign b_mc = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: f(x) is bit x of the truth table.
    function automatic logic model_f(input logic [7:0] tt, input int x);
        return logic'((tt >> x) & 8'd1);
    endfunction

    task automatic load_a(input logic [7:0] tt);
        a_cfg_we = 1'b1;
        a_cfg_tt = tt;
        tick();
        a_cfg_we = 1'b0;
    endtask

    task automatic eval_a(input logic [2:0] x);
        a_in_valid = 1'b1;
        a_in_x     = x;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input logic [7:0] tt_exp, input bit do_load,
                             input int stall_len, input bit with_req, input bit cfg_noise);
        logic [2:0] gx[$];
        logic       gf[$];
        int         done_c;
        int         stalled;
        if (do_load) load_a(tt_exp);
        a_out_ready   = 1'b1;
        a_sweep_start = 1'b1;
        if (with_req) begin
            a_in_valid = 1'b1;
            a_in_x     = 3'd5;
            #1;
            chk({tag, " in_ready at start"}, 32'(a_in_ready), 32'd0);
        end
        tick();
        a_sweep_start = 1'b0;
        a_in_valid    = 1'b0;
        chk({tag, " busy"}, 32'(a_sweep_busy), 32'd1);
        done_c  = 0;
        stalled = 0;
        for (int c = 1; c <= 60 && done_c == 0; c++) begin
            if (a_sweep_done) begin
                done_c = c;
            end else begin
                a_cfg_we    = cfg_noise && (c == 2 || c == 3);
                a_cfg_tt    = 8'hFF;
                a_out_ready = 1'b1;
                if (stall_len > 0 && stalled < stall_len && a_out_valid &&
                    (stalled > 0 || a_out_x == 3'd3)) begin
                    a_out_ready = 1'b0;
                    stalled++;
                    chk($sformatf("%s stall x c%0d", tag, c), 32'(a_out_x), 32'd3);
                    chk($sformatf("%s stall f c%0d", tag, c), 32'(a_out_f), 32'(model_f(tt_exp, 3)));
                end
                if (a_out_valid && a_out_ready) begin
                    gx.push_back(a_out_x);
                    gf.push_back(a_out_f);
                end
                tick();
            end
        end
        a_cfg_we    = 1'b0;
        a_out_ready = 1'b1;
        chk({tag, " done cycle"}, 32'(done_c), 32'(9 + stall_len));
        chk({tag, " result count"}, 32'(gx.size()), 32'd8);
        for (int i = 0; i < gx.size(); i++) begin
            chk($sformatf("%s x[%0d]", tag, i), 32'(gx[i]), 32'(i));
            chk($sformatf("%s f[%0d]", tag, i), 32'(gf[i]), 32'(model_f(tt_exp, i)));
        end
`ifdef FUNCAO_MINTERM_COUNT_EN
        chk({tag, " minterm_count"}, 32'(a_mc), 32'($countones(tt_exp)));
`endif
        chk({tag, " busy at done"}, 32'(a_sweep_busy), 32'd0);
        chk({tag, " valid at done"}, 32'(a_out_valid), 32'd0);
        tick();
        chk({tag, " done one pulse"}, 32'(a_sweep_done), 32'd0);
    endtask

    typedef struct {
        logic [7:0] tt;
        logic [2:0] x;
        logic       f;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] rtt;
        logic [2:0] rx;
        bit         hit;

        vecs[0] = '{tt: 8'h96, x: 3'd0, f: 1'b0};
        vecs[1] = '{tt: 8'h96, x: 3'd3, f: 1'b0};
        vecs[2] = '{tt: 8'h96, x: 3'd4, f: 1'b1};
        vecs[3] = '{tt: 8'h96, x: 3'd7, f: 1'b1};
        vecs[4] = '{tt: 8'hE8, x: 3'd1, f: 1'b0};
        vecs[5] = '{tt: 8'hE8, x: 3'd3, f: 1'b1};
        vecs[6] = '{tt: 8'hE8, x: 3'd5, f: 1'b1};
        vecs[7] = '{tt: 8'hE8, x: 3'd6, f: 1'b1};

        // Reset values
        #3;
        chk("reset out_valid", 32'(a_out_valid), 32'd0);
        chk("reset out_x", 32'(a_out_x), 32'd0);
        chk("reset out_f", 32'(a_out_f), 32'd0);
        chk("reset busy", 32'(a_sweep_busy), 32'd0);
        chk("reset done", 32'(a_sweep_done), 32'd0);
        chk("reset in_ready", 32'(a_in_ready), 32'd1);
        chk("reset minterm", 32'(a_mc), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // N=2: f = x & ~y
        b_cfg_we = 1'b1;
        b_cfg_tt = 4'b0100;
        tick();
        b_cfg_we   = 1'b0;
        b_in_valid = 1'b1;
        b_in_x     = 2'b10;
        tick();
        chk("n2 x=10 valid", 32'(b_out_valid), 32'd1);
        chk("n2 x=10 f", 32'(b_out_f), 32'd1);
        b_in_x = 2'b11;
        tick();
        b_in_valid = 1'b0;
        chk("n2 x=11 x", 32'(b_out_x), 32'd3);
        chk("n2 x=11 f", 32'(b_out_f), 32'd0);
        tick();
        chk("n2 drained", 32'(b_out_valid), 32'd0);

        // Table-driven single evaluations
        foreach (vecs[i]) begin
            load_a(vecs[i].tt);
            eval_a(vecs[i].x);
            chk($sformatf("vec%0d valid", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("vec%0d x", i), 32'(a_out_x), 32'(vecs[i].x));
            chk($sformatf("vec%0d f", i), 32'(a_out_f), 32'(vecs[i].f));
        end

        // cfg_we alongside an evaluation: old table applies to that result
        load_a(8'h0F);
        a_cfg_we   = 1'b1;
        a_cfg_tt   = 8'hF0;
        a_in_valid = 1'b1;
        a_in_x     = 3'd1;
        tick();
        a_cfg_we = 1'b0;
        chk("same-cycle cfg old f", 32'(a_out_f), 32'd1);
        tick();
        a_in_valid = 1'b0;
        chk("same-cycle cfg new f", 32'(a_out_f), 32'd0);

        // Random back-to-back evaluations against the model
        for (int r = 0; r < 4; r++) begin
            rtt = 8'($urandom);
            load_a(rtt);
            for (int k = 0; k < 6; k++) begin
                rx         = 3'($urandom_range(0, 7));
                a_in_valid = 1'b1;
                a_in_x     = rx;
                tick();
                chk($sformatf("rand%0d.%0d x", r, k), 32'(a_out_x), 32'(rx));
                chk($sformatf("rand%0d.%0d f", r, k), 32'(a_out_f), 32'(model_f(rtt, int'(rx))));
            end
            a_in_valid = 1'b0;
            tick();
        end

        // Sweeps
        run_sweep("parity", 8'b1001_0110, 1'b1, 0, 1'b0, 1'b0);
        run_sweep("stall", 8'b1001_0110, 1'b1, 3, 1'b0, 1'b0);
        run_sweep("collide", 8'b1001_0110, 1'b1, 0, 1'b1, 1'b1);
        rtt = 8'($urandom);
        run_sweep("rand sweep", rtt, 1'b1, $urandom_range(1, 4), 1'b0, 1'b0);

        // Reset in the middle of a sweep
        load_a(8'b1001_0110);
        a_sweep_start = 1'b1;
        tick();
        a_sweep_start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (a_out_valid && a_out_x == 3'd5) hit = 1'b1;
            else tick();
        end
        chk("reached idx 5", 32'(hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 32'(a_out_valid), 32'd0);
        chk("midreset out_x", 32'(a_out_x), 32'd0);
        chk("midreset out_f", 32'(a_out_f), 32'd0);
        chk("midreset busy", 32'(a_sweep_busy), 32'd0);
        chk("midreset in_ready", 32'(a_in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("midreset no done %0d", c), 32'(a_sweep_done), 32'd0);
        end
        #2;
        rst_n = 1'b1;
        tick();
        chk("post-reset no done", 32'(a_sweep_done), 32'd0);
        run_sweep("after reset", 8'h00, 1'b0, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
